id_inst_queue: RTL

//   Receiving end of the IF->ID handshake (fs_to_ds_valid/fs_to_ds_bus/ds_allow_in).
//   A small FIFO of fetched {pc,inst} pairs that decouples fetch from decode.

---
 rtl/id_inst_queue_pkg.sv | 19 +
 rtl/iq_entry_ram.sv | 27 ++
 rtl/id_inst_queue.sv | 95 +++++++++
 3 files changed

// File: rtl/id_inst_queue_pkg.sv
// Shared widths, entry layout and helpers for the IF->ID instruction queue.
// FS_TO_DS_BUS_WD, BR_BUS_WD and IQ_DEPTH mirror the mycpu.vh bus definitions.
package id_inst_queue_pkg;

   localparam int FS_TO_DS_BUS_WD = 64;
   localparam int BR_BUS_WD       = 33;
   localparam int IQ_DEPTH        = 4;
   localparam int FLUSH_CNT_W     = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;

   function automatic logic [FLUSH_CNT_W-1:0] sat_inc(input logic [FLUSH_CNT_W-1:0] v);
      return (v == {FLUSH_CNT_W{1'b1}}) ? v : v + {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/iq_entry_ram.sv
// DEPTH x 64 entry storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the queue count.
module iq_entry_ram
   import id_inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int AW    = 2
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [AW-1:0]              waddr,
   input  logic [FS_TO_DS_BUS_WD-1:0] wdata,
   input  logic [AW-1:0]              raddr,
   output logic [FS_TO_DS_BUS_WD-1:0] rdata
);

   logic [FS_TO_DS_BUS_WD-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/id_inst_queue.sv
// IF->ID decoupling FIFO of {pc,inst}; first-word-fall-through head to decode,
// flushed to empty by a taken branch, with a saturating count of effective flushes.
module id_inst_queue
   import id_inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int AW    = 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       fs_to_ds_valid,
   input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   output logic                       ds_allow_in,
   input  logic [BR_BUS_WD-1:0]       brbus,
   output logic                       iq_valid,
   output logic [31:0]                iq_pc,
   output logic [31:0]                iq_inst,
   input  logic                       ds_ready,
   output logic [AW:0]                iq_count,
   output logic [FLUSH_CNT_W-1:0]     flush_cnt
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0]              wr_ptr;
   logic [AW-1:0]              rd_ptr;
   logic [AW:0]                count;
   logic [FLUSH_CNT_W-1:0]     flush_cnt_q;
   logic                       br_taken;
   logic                       push;
   logic                       pop;
   logic                       flush_hit;
   logic [FS_TO_DS_BUS_WD-1:0] head_raw;
   iq_entry_t                  head;

   assign br_taken = brbus[BR_BUS_WD-1];

   // Allow depends only on registered state so fetch never sees a ds_ready loop.
   assign ds_allow_in = resetn && (count != FULL_CNT);
   assign iq_valid    = resetn && (count != '0) && !br_taken;

   assign push      = fs_to_ds_valid && ds_allow_in && !br_taken;
   assign pop       = iq_valid && ds_ready;
   assign flush_hit = (count != '0) || (fs_to_ds_valid && ds_allow_in);

   iq_entry_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (fs_to_ds_bus),
      .raddr (rd_ptr),
      .rdata (head_raw)
   );

   assign head    = iq_entry_t'(head_raw);
   assign iq_pc   = iq_valid ? head.pc   : 32'd0;
   assign iq_inst = iq_valid ? head.inst : 32'd0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         flush_cnt_q <= '0;
      end else if (br_taken) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         if (flush_hit) begin
            flush_cnt_q <= sat_inc(flush_cnt_q);
         end
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign iq_count  = count;
   assign flush_cnt = flush_cnt_q;

endmodule
